// File: rtl/freq_lock_monitor_pkg.sv
// Shared types for the frequency lock monitor: lock FSM encoding and
// gate-counter width helper.
package freq_lock_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    function automatic int unsigned gate_cnt_w(input int unsigned cycles);
        return (cycles > 32'd1) ? $clog2(cycles) : 32'd1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input followed by a one-cycle
// rising-edge pulse in the destination clock domain.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    // Synchronizer chain plus one delay flop for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/freq_lock_monitor.sv
// Gated edge counter with min/max band check and lock FSM for an asynchronous
// periodic signal. Optional count_min_o/count_max_o: FREQ_LOCK_MONITOR_STATS_EN.
module freq_lock_monitor
    import freq_lock_monitor_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 80000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_COUNT  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             sig_i,
    input  logic [CNT_W-1:0] min_count_i,
    input  logic [CNT_W-1:0] max_count_i,
    output logic [CNT_W-1:0] count_o,
    output logic             count_valid_o,
    output logic             in_range_o,
    output logic             locked_o,
    output logic             lost_o
`ifdef FREQ_LOCK_MONITOR_STATS_EN
    ,
    output logic [CNT_W-1:0] count_min_o,
    output logic [CNT_W-1:0] count_max_o
`endif
);

    localparam int unsigned GATE_W = gate_cnt_w(GATE_CYCLES);
    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [GATE_W-1:0] GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
    localparam logic [GATE_W-1:0] GATE_ONE    = GATE_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_ONE    = GOOD_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_COUNT);

    state_e              state_q, state_d;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic                ovf_q, ovf_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                count_valid_q, count_valid_d;
    logic                in_range_q, in_range_d;
    logic                locked_q, locked_d;
    logic                lost_q, lost_d;

    logic                edge_s;
    logic [CNT_W-1:0]    win_cnt_s;
    logic                win_ovf_s;
    logic                win_in_s;
    logic                terminal_s;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (sig_i),
        .edge_o  (edge_s)
    );

    // Window accounting, band check and lock FSM next-state
    always_comb begin
        state_d       = state_q;
        gate_d        = gate_q;
        edge_cnt_d    = edge_cnt_q;
        ovf_d         = ovf_q;
        good_d        = good_q;
        count_d       = count_q;
        in_range_d    = in_range_q;
        count_valid_d = 1'b0;
        lost_d        = 1'b0;

        // An edge on the terminal cycle still belongs to the closing window
        win_ovf_s  = ovf_q | (edge_s & (edge_cnt_q == CNT_MAX));
        if (edge_s && (edge_cnt_q != CNT_MAX)) begin
            win_cnt_s = edge_cnt_q + CNT_ONE;
        end else begin
            win_cnt_s = edge_cnt_q;
        end
        win_in_s   = !win_ovf_s && (min_count_i <= win_cnt_s) && (win_cnt_s <= max_count_i);
        terminal_s = (gate_q == GATE_LAST);

        case (state_q)
            ST_IDLE: begin
                gate_d     = '0;
                edge_cnt_d = '0;
                ovf_d      = 1'b0;
                good_d     = '0;
                if (enable_i) begin
                    state_d = ST_ACQUIRE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACQUIRE, ST_LOCKED: begin
                if (!enable_i) begin
                    state_d    = ST_IDLE;
                    gate_d     = '0;
                    edge_cnt_d = '0;
                    ovf_d      = 1'b0;
                    good_d     = '0;
                end else if (terminal_s) begin
                    gate_d        = '0;
                    edge_cnt_d    = '0;
                    ovf_d         = 1'b0;
                    count_d       = win_cnt_s;
                    in_range_d    = win_in_s;
                    count_valid_d = 1'b1;
                    if (state_q == ST_ACQUIRE) begin
                        if (!win_in_s) begin
                            good_d = '0;
                        end else if ((good_q + GOOD_ONE) == GOOD_TARGET) begin
                            state_d = ST_LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + GOOD_ONE;
                        end
                    end else if (!win_in_s) begin
                        state_d = ST_ACQUIRE;
                        lost_d  = 1'b1;
                        good_d  = '0;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end else begin
                    gate_d     = gate_q + GATE_ONE;
                    edge_cnt_d = win_cnt_s;
                    ovf_d      = win_ovf_s;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                gate_d     = '0;
                edge_cnt_d = '0;
                ovf_d      = 1'b0;
                good_d     = '0;
            end
        endcase

        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            gate_q        <= '0;
            edge_cnt_q    <= '0;
            ovf_q         <= 1'b0;
            good_q        <= '0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            in_range_q    <= 1'b0;
            locked_q      <= 1'b0;
            lost_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            gate_q        <= gate_d;
            edge_cnt_q    <= edge_cnt_d;
            ovf_q         <= ovf_d;
            good_q        <= good_d;
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
            in_range_q    <= in_range_d;
            locked_q      <= locked_d;
            lost_q        <= lost_d;
        end
    end

    assign count_o       = count_q;
    assign count_valid_o = count_valid_q;
    assign in_range_o    = in_range_q;
    assign locked_o      = locked_q;
    assign lost_o        = lost_q;

`ifdef FREQ_LOCK_MONITOR_STATS_EN
    logic [CNT_W-1:0] cmin_q, cmin_d;
    logic [CNT_W-1:0] cmax_q, cmax_d;

    // Extremes restart on every fresh acquisition out of IDLE
    always_comb begin
        cmin_d = cmin_q;
        cmax_d = cmax_q;
        if ((state_q == ST_IDLE) && (state_d == ST_ACQUIRE)) begin
            cmin_d = CNT_MAX;
            cmax_d = '0;
        end else if (count_valid_d) begin
            cmin_d = (count_d < cmin_q) ? count_d : cmin_q;
            cmax_d = (count_d > cmax_q) ? count_d : cmax_q;
        end else begin
            cmin_d = cmin_q;
            cmax_d = cmax_q;
        end
    end

    // Statistics registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmin_q <= CNT_MAX;
            cmax_q <= '0;
        end else begin
            cmin_q <= cmin_d;
            cmax_q <= cmax_d;
        end
    end

    assign count_min_o = cmin_q;
    assign count_max_o = cmax_q;
`else
    // Statistics disabled: no extreme-value tracking registers.
`endif

endmodule

// File: tb/tb_freq_lock_monitor.sv
// Randomized bench for freq_lock_monitor against a window-level behavioural
// model, plus scenario checks for lock, loss, overflow, abort and reset.
module tb_freq_lock_monitor;

    localparam int unsigned GATE = 100;
    localparam int unsigned CNTW = 4;
    localparam int unsigned SYNC = 2;
    localparam int unsigned LOCK = 3;
    localparam int          CMAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst, en, sig;
    logic [CNTW-1:0] min_c, max_c;
    logic [CNTW-1:0] count_o;
    logic            count_valid_o, in_range_o, locked_o, lost_o;
`ifdef FREQ_LOCK_MONITOR_STATS_EN
    logic [CNTW-1:0] count_min_o, count_max_o;
`endif

    always #5 clk = ~clk;

    freq_lock_monitor #(
        .GATE_CYCLES (GATE),
        .CNT_W       (CNTW),
        .SYNC_STAGES (SYNC),
        .LOCK_COUNT  (LOCK)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (en),
        .sig_i         (sig),
        .min_count_i   (min_c),
        .max_count_i   (max_c),
        .count_o       (count_o),
        .count_valid_o (count_valid_o),
        .in_range_o    (in_range_o),
        .locked_o      (locked_o),
        .lost_o        (lost_o)
`ifdef FREQ_LOCK_MONITOR_STATS_EN
        ,
        .count_min_o   (count_min_o),
        .count_max_o   (count_max_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: sig_i history, window position and raw edge total
    bit              started = 1'b0;
    bit              hist [SYNC+2];
    int              mode = 0;          // 0 idle, 1 acquiring, 2 locked
    int              pos = 0, raw_cnt = 0, run_len = 0;
    logic [CNTW-1:0] exp_count = '0, exp_min = '1, exp_max = '0;
    bit              exp_valid = 1'b0, exp_in = 1'b0, exp_locked = 1'b0, exp_lost = 1'b0;

    initial begin
        for (int k = 0; k < SYNC + 2; k++) hist[k] = 1'b0;
        forever begin
            @(posedge clk);
            begin
                bit e, ovf, inb;
                int sat;
                for (int k = SYNC + 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = sig;
                // an input rise becomes visible SYNC cycles later
                e = hist[SYNC] & ~hist[SYNC+1];
                exp_valid = 1'b0;
                exp_lost  = 1'b0;
                if (rst) begin
                    started = 1'b1;
                    for (int k = 0; k < SYNC + 2; k++) hist[k] = 1'b0;
                    mode = 0; pos = 0; raw_cnt = 0; run_len = 0;
                    exp_count = '0; exp_in = 1'b0; exp_min = '1; exp_max = '0;
                end else if (mode == 0) begin
                    if (en) begin
                        mode = 1; pos = 0; raw_cnt = 0; run_len = 0;
                        exp_min = '1; exp_max = '0;
                    end
                end else if (!en) begin
                    mode = 0; pos = 0; raw_cnt = 0; run_len = 0;
                end else begin
                    raw_cnt += int'(e);
                    if (pos == GATE - 1) begin
                        ovf = (raw_cnt > CMAX);
                        sat = ovf ? CMAX : raw_cnt;
                        inb = !ovf && (int'(min_c) <= sat) && (sat <= int'(max_c));
                        exp_count = CNTW'(sat);
                        exp_valid = 1'b1;
                        exp_in    = inb;
                        if (exp_count < exp_min) exp_min = exp_count;
                        if (exp_count > exp_max) exp_max = exp_count;
                        if (mode == 1) begin
                            run_len = inb ? run_len + 1 : 0;
                            if (run_len >= LOCK) begin
                                mode = 2;
                                run_len = 0;
                            end
                        end else if (!inb) begin
                            mode = 1;
                            run_len = 0;
                            exp_lost = 1'b1;
                        end
                        raw_cnt = 0;
                        pos = 0;
                    end else begin
                        pos++;
                    end
                end
                exp_locked = (mode == 2);
            end
        end
    end

    int              lost_seen = 0, valid_seen = 0;
    logic [CNTW-1:0] seen [$];

    // Per-cycle comparison against the model on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("count_o", count_o, exp_count);
                chk("count_valid_o", count_valid_o, exp_valid);
                chk("in_range_o", in_range_o, exp_in);
                chk("locked_o", locked_o, exp_locked);
                chk("lost_o", lost_o, exp_lost);
`ifdef FREQ_LOCK_MONITOR_STATS_EN
                chk("count_min_o", count_min_o, exp_min);
                chk("count_max_o", count_max_o, exp_max);
`endif
                if (lost_o === 1'b1) lost_seen++;
                if (count_valid_o === 1'b1) begin
                    valid_seen++;
                    seen.push_back(count_o);
                end
            end
        end
    end

    int period = 0, ph = 0;

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (period == 0) begin
                sig = 1'b0;
            end else begin
                ph  = ph % period;
                sig = (ph < period / 2);
                ph  = (ph + 1) % period;
            end
        end
    endtask

    task automatic pulse_window(input int n);
        for (int i = 0; i < GATE; i++) begin
            @(posedge clk); #1;
            sig = (i >= 10) && (i < 10 + 7 * n) && (((i - 10) % 7) < 2);
        end
    endtask

    task automatic set_en(input bit v);
        @(posedge clk); #1;
        en = v;
        ph = $urandom_range(0, 9);
    endtask

    initial begin
        int lost0, valid0;
        rst = 1'b1; en = 1'b0; sig = 1'b0; min_c = 4'd9; max_c = 4'd11;
        run(3);
        rst = 1'b0;
        chk("reset_count", count_o, 32'd0);
        chk("reset_valid", count_valid_o, 32'd0);
        chk("reset_in_range", in_range_o, 32'd0);
        chk("reset_locked", locked_o, 32'd0);
        chk("reset_lost", lost_o, 32'd0);
        run(5);

        // Acquire with period 10: lock at the close of the 3rd window
        period = 10;
        set_en(1'b1);
        run(250);
        chk("pre_lock_locked", locked_o, 32'd0);
        run(100);
        chk("lock_locked", locked_o, 32'd1);
        chk("lock_count_band", (count_o >= 4'd9) && (count_o <= 4'd11), 32'd1);
        chk("lock_no_lost", lost_seen, 32'd0);

        // Period 5 saturates the 4-bit counter: one loss, then stay unlocked
        lost0 = lost_seen;
        period = 5;
        run(200);
        chk("loss_count", count_o, 32'd15);
        chk("loss_in_range", in_range_o, 32'd0);
        chk("loss_locked", locked_o, 32'd0);
        chk("loss_once", lost_seen - lost0, 32'd1);
        period = 10;
        run(300);
        chk("relock_early", locked_o, 32'd0);
        run(100);
        chk("relock_locked", locked_o, 32'd1);

        // Overflow with max=15 never counts as in band
        min_c = 4'd0; max_c = 4'd15; period = 2;
        run(500);
        chk("ovf_count", count_o, 32'd15);
        chk("ovf_in_range", in_range_o, 32'd0);
        chk("ovf_locked", locked_o, 32'd0);

        // Two good windows, one out-of-band window, then three more good
        min_c = 4'd9; max_c = 4'd11; period = 10;
        set_en(1'b0);
        run(3);
        set_en(1'b1);
        run(249);
        max_c = 4'd5;
        run(100);
        max_c = 4'd11;
        run(200);
        chk("restart_not_locked", locked_o, 32'd0);
        run(100);
        chk("restart_locked", locked_o, 32'd1);

        // Abortive disable mid-window while locked
        run(40);
        lost0 = lost_seen; valid0 = valid_seen;
        set_en(1'b0);
        run(1);
        chk("abort_locked", locked_o, 32'd0);
        chk("abort_count_held", count_o, 32'd10);
        chk("abort_in_range_held", in_range_o, 32'd1);
        run(5);
        chk("abort_no_lost", lost_seen - lost0, 32'd0);
        chk("abort_no_valid", valid_seen - valid0, 32'd0);

        // Reset mid-window
        set_en(1'b1);
        run(150);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        chk("midrst_count", count_o, 32'd0);
        chk("midrst_in_range", in_range_o, 32'd0);
        chk("midrst_locked", locked_o, 32'd0);
        chk("midrst_valid", count_valid_o, 32'd0);

        // Inverted band: never in range
        min_c = 4'd12; max_c = 4'd8;
        valid0 = valid_seen;
        run(500);
        chk("inv_in_range", in_range_o, 32'd0);
        chk("inv_locked", locked_o, 32'd0);
        chk("inv_windows", valid_seen - valid0 >= 4, 32'd1);

        // Window counts 10, 12, 9 from a fresh acquisition
        min_c = 4'd0; max_c = 4'd15; period = 0;
        set_en(1'b0);
        run(5);
        set_en(1'b1);
        pulse_window(10);
        pulse_window(12);
        pulse_window(9);
        run(5);
        chk("stat_win1", seen[seen.size()-3], 32'd10);
        chk("stat_win2", seen[seen.size()-2], 32'd12);
        chk("stat_win3", seen[seen.size()-1], 32'd9);
`ifdef FREQ_LOCK_MONITOR_STATS_EN
        chk("stat_min", count_min_o, 32'd9);
        chk("stat_max", count_max_o, 32'd12);
`endif

        // Randomized periods, bands and enable drops
        for (int r = 0; r < 12; r++) begin
            period = $urandom_range(0, 20);
            min_c  = CNTW'($urandom_range(0, 15));
            max_c  = CNTW'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) set_en(~en);
            run($urandom_range(50, 300));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
